// File: rtl/gray_sum.sv
// gray_sum: sums three weighted channel products into a grayscale pixel,
// clips to full scale and hands it downstream on a valid/ready handshake.
module gray_sum #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i_gray_sum,
  input  logic              rstn_i_gray_sum,
  input  logic              en_i_gray_sum,
  input  logic [DATA_W-1:0] result_i_R,
  input  logic [DATA_W-1:0] result_i_G,
  input  logic [DATA_W-1:0] result_i_B,
  input  logic              mult_done_i,
  input  logic              gray_ready_i,
  output logic [DATA_W-1:0] gray_o,
  output logic              gray_valid_o,
  output logic              sat_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  pix_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    ACC,
    SAT,
    HOLD
  } state_t;

  localparam int SUM_W = DATA_W + 2;

  state_t            state_q, state_d;
  logic              done_q;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] gray_q, gray_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cap;
  logic              over;

  assign cap  = mult_done_i & ~done_q;
  assign over = |sum_q[SUM_W-1:DATA_W];

  // Next-state and datapath updates for the capture/sum/clip/hold sequence
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    sum_d   = sum_q;
    gray_d  = gray_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cap && en_i_gray_sum) begin
          r_d     = result_i_R;
          g_d     = result_i_G;
          b_d     = result_i_B;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d   = {2'b00, r_q} + {2'b00, g_q};
        state_d = ACC;
      end
      ACC: begin
        sum_d   = sum_q + {2'b00, b_q};
        state_d = SAT;
      end
      SAT: begin
        if (over) begin
          gray_d = {DATA_W{1'b1}};
          sat_d  = 1'b1;
        end else begin
          gray_d = sum_q[DATA_W-1:0];
          sat_d  = 1'b0;
        end
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (gray_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cap && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i_gray_sum or negedge rstn_i_gray_sum) begin
    if (!rstn_i_gray_sum) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= mult_done_i;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gray_o       = gray_q;
  assign gray_valid_o = valid_q;
  assign sat_o        = sat_q;
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = ovr_q;
  assign pix_cnt_o    = cnt_q;

endmodule

// File: tb/tb_gray_sum.sv
// tb_gray_sum: directed and random checks of gray_sum against a
// transaction-level model; a 2-bit-counter copy covers wrap.
module tb_gray_sum;

  localparam int DW = 10;
  localparam int FS = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic md = 1'b0;
  logic rdy = 1'b0;
  logic [DW-1:0] r = '0;
  logic [DW-1:0] g = '0;
  logic [DW-1:0] b = '0;

  logic [DW-1:0] ga, gb;
  logic va, vb, sa, sb, ba, bb, oa, ob;
  logic [15:0] ca;
  logic [1:0] cb;

  gray_sum #(.DATA_W(DW), .CNT_W(16)) dut_a (
    .clk_i_gray_sum (clk),
    .rstn_i_gray_sum(rst_n),
    .en_i_gray_sum  (en),
    .result_i_R     (r),
    .result_i_G     (g),
    .result_i_B     (b),
    .mult_done_i    (md),
    .gray_ready_i   (rdy),
    .gray_o         (ga),
    .gray_valid_o   (va),
    .sat_o          (sa),
    .busy_o         (ba),
    .overrun_o      (oa),
    .pix_cnt_o      (ca)
  );

  gray_sum #(.DATA_W(DW), .CNT_W(2)) dut_b (
    .clk_i_gray_sum (clk),
    .rstn_i_gray_sum(rst_n),
    .en_i_gray_sum  (en),
    .result_i_R     (r),
    .result_i_G     (g),
    .result_i_B     (b),
    .mult_done_i    (md),
    .gray_ready_i   (rdy),
    .gray_o         (gb),
    .gray_valid_o   (vb),
    .sat_o          (sb),
    .busy_o         (bb),
    .overrun_o      (ob),
    .pix_cnt_o      (cb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Transaction-level model: a pixel is accepted when idle, appears
  // three edges later as min(R+G+B, full scale), and leaves on ready.
  bit m_done, m_pend, m_valid, m_sat, m_ovr;
  int m_lat, m_sum, m_gray, m_cnt;

  initial begin
    m_done = 0; m_pend = 0; m_valid = 0; m_sat = 0; m_ovr = 0;
    m_lat = 0; m_sum = 0; m_gray = 0; m_cnt = 0;
    forever begin
      bit s_rst, s_en, s_md, s_rdy, cap;
      int s_r, s_g, s_b;
      @(posedge clk);
      s_rst = rst_n; s_en = en; s_md = md; s_rdy = rdy;
      s_r = int'(r); s_g = int'(g); s_b = int'(b);
      if (!s_rst) begin
        m_done = 0; m_pend = 0; m_valid = 0; m_sat = 0; m_ovr = 0;
        m_lat = 0; m_sum = 0; m_gray = 0; m_cnt = 0;
      end else begin
        cap = s_md && !m_done;
        m_done = s_md;
        if (!m_pend) begin
          if (cap && s_en) begin
            m_pend = 1;
            m_lat = 3;
            m_sum = s_r + s_g + s_b;
          end
        end else begin
          if (cap) m_ovr = 1;
          if (m_lat > 0) begin
            m_lat--;
            if (m_lat == 0) begin
              m_valid = 1;
              m_sat = (m_sum > FS);
              m_gray = m_sat ? FS : m_sum;
            end
          end else if (s_rdy) begin
            m_valid = 0;
            m_pend = 0;
            m_cnt++;
          end
        end
      end
      #1;
      check("gray", int'(ga), m_gray);
      check("valid", int'(va), int'(m_valid));
      check("sat", int'(sa), int'(m_sat));
      check("busy", int'(ba), int'(m_pend));
      check("overrun", int'(oa), int'(m_ovr));
      check("cnt16", int'(ca), m_cnt % 65536);
      check("cnt2", int'(cb), m_cnt % 4);
      check("gray_b", int'(gb), m_gray);
      check("valid_b", int'(vb), int'(m_valid));
      check("sat_b", int'(sb), int'(m_sat));
      check("busy_b", int'(bb), int'(m_pend));
      check("overrun_b", int'(ob), int'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_pixel(input logic [DW-1:0] ri, input logic [DW-1:0] gi,
                           input logic [DW-1:0] bi, input int stall,
                           output int lat);
    logic [DW-1:0] g0;
    r = ri; g = gi; b = bi;
    en = 1'b1; md = 1'b1;
    rdy = (stall == 0);
    step();
    md = 1'b0;
    lat = 0;
    while (!va && lat < 10) begin
      step();
      lat++;
    end
    if (!va) check("valid_timeout", 0, 1);
    g0 = ga;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", int'(va), 1);
      check("stall_gray", int'(ga), int'(g0));
    end
    rdy = 1'b1;
    step();
    check("hs_valid_low", int'(va), 0);
    rdy = 1'b0;
  endtask

  initial begin
    int lat, c0, nv;
    int wrap_exp[4];
    wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_gray", int'(ga), 0);
    check("rst_valid", int'(va), 0);
    check("rst_cnt", int'(ca), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_pixel(10'h099, 10'h12C, 10'h03A, 0, lat);
    check("basic_latency", lat, 3);
    check("basic_gray", int'(ga), 'h1FF);
    check("basic_sat", int'(sa), 0);
    check("basic_cnt", int'(ca), 1);
    step();

    run_pixel(10'h3FF, 10'h3FF, 10'h001, 0, lat);
    check("sat_gray", int'(ga), 'h3FF);
    check("sat_flag", int'(sa), 1);
    step();

    c0 = int'(ca);
    run_pixel(10'h010, 10'h020, 10'h030, 5, lat);
    check("bp_gray", int'(ga), 'h060);
    check("bp_cnt", int'(ca), c0 + 1);
    step();

    r = 10'h001; g = 10'h002; b = 10'h003;
    en = 1'b1; md = 1'b1; rdy = 1'b1;
    step();
    md = 1'b0;
    step();
    md = 1'b1;
    step();
    md = 1'b0;
    check("ovr_set", int'(oa), 1);
    c0 = int'(ca);
    for (int i = 0; i < 10; i++) step();
    check("ovr_one_pixel", int'(ca), c0 + 1);
    run_pixel(10'h004, 10'h004, 10'h004, 0, lat);
    check("ovr_sticky", int'(oa), 1);
    do_reset();
    check("ovr_cleared", int'(oa), 0);
    step();

    c0 = int'(ca);
    nv = 0;
    md = 1'b1; en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (va) nv++;
    end
    md = 1'b0;
    step();
    check("level_valids", nv, 1);
    check("level_cnt", int'(ca), c0 + 1);

    r = 10'h100; g = 10'h100; b = 10'h100;
    md = 1'b1; rdy = 1'b1;
    step();
    md = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(ba), 0);
    check("midrst_gray", int'(ga), 0);
    check("midrst_valid", int'(va), 0);
    check("midrst_sat", int'(sa), 0);
    check("midrst_cnt", int'(ca), 0);
    md = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_capture", int'(ba), 1);
    md = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (va) nv++;
    end
    check("post_rst_pixel", nv, 1);

    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      run_pixel(DW'($urandom_range(0, FS)), DW'($urandom_range(0, FS)),
                DW'($urandom_range(0, FS)), i, lat);
      check("wrap_cnt", int'(cb), wrap_exp[i]);
    end

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      en = ($urandom_range(0, 3) != 0);
      md = ($urandom_range(0, 2) == 0) ? ~md : md;
      rdy = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 1) == 0) begin
        r = DW'($urandom_range(0, FS));
        g = DW'($urandom_range(0, FS));
        b = DW'($urandom_range(0, FS));
      end else begin
        r = DW'($urandom_range(0, 400));
        g = DW'($urandom_range(0, 400));
        b = DW'($urandom_range(0, 400));
      end
    end
    rst_n = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gray_sum.md
GRAY_SUM -- requirements
Module: gray_sum

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning channel and result width in unsigned Q1.9 fixed point.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the delivered-pixel counter.
REQ-003 SHALL have port clk_i_gray_sum, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i_gray_sum, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en_i_gray_sum, input, 1, capture enable.
REQ-006 SHALL have ports result_i_R, result_i_G and result_i_B, each input, DATA_W, the weighted channel products from the upstream multiplier.
REQ-007 SHALL have port mult_done_i, input, 1, the upstream completion level.
REQ-008 SHALL have port gray_ready_i, input, 1, downstream ready.
REQ-009 SHALL have port gray_o, output, DATA_W, the grayscale result.
REQ-010 SHALL have port gray_valid_o, output, 1, result valid.
REQ-011 SHALL have port sat_o, output, 1, set when the current gray_o was clipped.
REQ-012 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-013 SHALL have port overrun_o, output, 1, sticky error flag.
REQ-014 SHALL have port pix_cnt_o, output, CNT_W, the count of delivered pixels.

Function
REQ-015 SHALL register mult_done_i into done_q every cycle, regardless of state; a capture event is mult_done_i=1 AND done_q=0.
REQ-016 SHALL implement the FSM states IDLE, ADD, ACC, SAT and HOLD.
REQ-017 In IDLE, a capture event with en_i_gray_sum=1 at edge k SHALL load R, G and B into internal registers and go to ADD; a capture event with enable low is discarded.
REQ-018 At edge k+1 the block SHALL compute sum = R+G in a register of DATA_W+2 bits and go to ACC.
REQ-019 At edge k+2 the block SHALL compute sum = sum+B and go to SAT.
REQ-020 At edge k+3 the block SHALL load gray_o and go to HOLD with gray_valid_o=1.
  - If sum > 2^DATA_W-1: gray_o = all ones, sat_o=1.
  - Otherwise: gray_o = sum[DATA_W-1:0], sat_o=0.
  - Latency from the capture edge to valid is 3 clocks.
REQ-021 In HOLD, gray_o, sat_o and gray_valid_o SHALL stay stable until an edge where gray_ready_i=1.
  - At that edge: gray_valid_o←0, pix_cnt_o←pix_cnt_o+1, state←IDLE.
  - gray_o and sat_o keep their last values after the handshake.
REQ-022 If gray_ready_i is already high when valid rises, gray_valid_o SHALL be high for exactly one cycle.
REQ-023 pix_cnt_o SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-024 A capture event in any state other than IDLE (including the HOLD handshake edge) SHALL be dropped and set overrun_o=1; overrun_o clears only on reset.
REQ-025 Deasserting en_i_gray_sum mid-operation SHALL NOT abort it; the pending pixel completes and is delivered.
REQ-026 mult_done_i held high across several pixels SHALL produce only one capture; a new capture requires a low cycle first.

Reset
REQ-027 On rstn_i_gray_sum=0, immediately and asynchronously, the block SHALL set:
  - state=IDLE and done_q=0;
  - the R, G, B and sum registers to 0;
  - gray_o=0, gray_valid_o=0, sat_o=0, busy_o=0, overrun_o=0, pix_cnt_o=0.
REQ-028 Reset asserted mid-operation SHALL discard the pixel in flight with no output.
REQ-029 After reset release, mult_done_i already high SHALL be captured at the first edge with en_i_gray_sum=1, since done_q=0.

Verification
REQ-030 Basic: R=10'h099, G=10'h12C, B=10'h03A, mult_done_i rising, ready=1 -> gray_o=10'h1FF, sat_o=0, valid exactly 3 clocks after capture for one cycle, pix_cnt_o=1.
REQ-031 Saturation: R=10'h3FF, G=10'h3FF, B=10'h001 -> gray_o=10'h3FF, sat_o=1.
REQ-032 Backpressure: ready=0 for 5 cycles after valid -> gray_o and gray_valid_o stable all 5 cycles, one handshake when ready rises, pix_cnt_o increments by exactly 1.
REQ-033 Overrun and level hold:
  - mult_done_i toggles low then high while busy_o=1 -> second pixel dropped, overrun_o=1 persists until reset.
  - mult_done_i held high for 20 cycles -> exactly one pixel delivered.
REQ-034 Reset mid-op: assert reset in ACC -> all outputs 0 immediately, no valid pulse for that pixel.
REQ-035 Wrap: CNT_W=2, 4 handshakes -> pix_cnt_o sequence 1, 2, 3, 0.
